conv_seq_ctrl: RTL
==================

# conv_seq_ctrl

Sequencer that shares one combinational 4-bit Excess-3→BCD converter (E in, B/v out) across a multi-digit word. Accepts a packed word of NDIG Excess-3 digits on a start pulse and drives one digit per cycle into the external converter. Collects each BCD digit and its valid flag, then presents the packed BCD result with a per-digit error mask and a one-cycle done pulse. Sits between the converter datapath and any upstream client needing whole-word conversion.

## Interface
- NDIG, 4, number of 4-bit digits per word (≥1); word width W = 4*NDIG
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; sampled only in IDLE
- word_in  input  W  Excess-3 digits; digit i = word_in[4i+3:4i]; digit 0 processed first
- conv_e  output  4  digit driven to shared converter E input
- conv_b  input  4  converter B output (combinational from conv_e)
- conv_v  input  1  converter v output; 1 = E in 0011..1100
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse, result valid
- bcd_out  output  W  packed BCD result; digit i at [4i+3:4i]
- err_mask  output  NDIG  bit i = digit i invalid
- err  output  1  OR of err_mask

## Operation
- States: IDLE, CONV, DONE.
- IDLE: start=1 at edge → latch word_in into word_q, idx←0, state←CONV. Otherwise stay.
- CONV: conv_e = word_q digit idx (registered-path mux, stable whole cycle). At each edge capture: conv_v=1 → digit idx of result ← conv_b, mask bit ← 0; conv_v=0 → digit ← 4'hF, mask bit ← 1. idx=NDIG-1 → state←DONE, else idx←idx+1.
- DONE: done=1, bcd_out/err_mask/err present new result; next edge → IDLE.
- Result registers (bcd_out, err_mask, err) update atomically on the edge entering DONE; hold value at all other times, including through next CONV.
- start while busy ignored, not queued. word_in changes after acceptance have no effect.
- conv_e = 4'b0000 in IDLE and DONE.
- rst=1 at an edge, any state: state←IDLE, idx←0, conv_e←0, busy←0, done←0, bcd_out←0, err_mask←0, err←0. Reset mid-CONV aborts; no done pulse.

## Timing
- Start sampled at edge 0 → CONV captures at edges 1..NDIG → done high in the cycle after edge NDIG → IDLE at edge NDIG+1.
- Latency: done visible NDIG edges after start edge. Throughput: one word per NDIG+2 cycles with start held high.
- busy rises after edge 0, falls after edge NDIG+1.
- Converter is combinational; conv_b/conv_v must settle within the cycle conv_e is driven.

## Configuration
- CONV_EARLY_ABORT_EN defined: first capture with conv_v=0 sets that digit to 4'hF and its mask bit. It also sets all unprocessed digits to 4'hF with mask bits 0, and moves the state to DONE at that same edge. done then comes k+1 edges after start, where k is the failing digit index.
- Undefined: all NDIG digits always converted. Fixed latency NDIG, full error mask reported.

## Test plan
- Reset, then start with word_in=16'h3456 → conv_e sequence 6,5,4,3 → done after edge 4, bcd_out=16'h0123, err_mask=4'b0000, err=0.
- word_in=16'hC3A0 (macro off) → bcd_out=16'h907F, err_mask=4'b0001, err=1, done after edge 4. Macro on → done after edge 1, bcd_out=16'hFFFF, err_mask=4'b0001.
- Start pulse at edge 2 of a conversion with different word_in → ignored. Single done, result of first word only.
- Start held high continuously with 16'h3333 → done pulses every 6 cycles, bcd_out=16'h0000 each time.
- rst asserted at edge 2 of CONV → next cycle all outputs 0, no done pulse. Fresh start afterwards converts correctly.
- All 16 single-digit codes through digit 0 (others 4'h3) → v pattern matches 0011..1100 valid. Invalid digits produce 4'hF with err set.

Source files
------------

// File: rtl/conv_seq_ctrl_if.sv
// Client-side bus of the Excess-3 -> BCD word sequencer.
//   start     : conversion request (sampled only while idle)
//   word_in   : NDIG packed Excess-3 digits, digit 0 in bits [3:0]
//   busy      : sequencer not idle
//   done      : one-cycle pulse, result valid
//   bcd_out   : packed BCD result, invalid digits read 4'hF
//   err_mask  : per-digit invalid flags
//   err       : OR of err_mask
// master = upstream client, slave = sequencer.
interface conv_seq_ctrl_if #(
  parameter int NDIG = 4
);
  logic                start;
  logic [4*NDIG-1:0]   word_in;
  logic                busy;
  logic                done;
  logic [4*NDIG-1:0]   bcd_out;
  logic [NDIG-1:0]     err_mask;
  logic                err;

  modport master (
    output start, word_in,
    input  busy, done, bcd_out, err_mask, err
  );

  modport slave (
    input  start, word_in,
    output busy, done, bcd_out, err_mask, err
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Word sequencer sharing one combinational Excess-3 -> BCD converter.
// A start request latches an NDIG-digit word; one digit per cycle is driven
// on conv_e and the converter's conv_b/conv_v answer is captured at the next
// edge. The packed result, error mask and a one-cycle done pulse are
// presented together once every digit (or the first bad one) is handled.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : client interface (conv_seq_ctrl_if.slave)
//   conv_e  : digit driven to the shared converter (0 when not converting)
//   conv_b  : converter BCD output
//   conv_v  : converter valid flag
//
// Optional feature macro: CONV_EARLY_ABORT_EN
//   defined   -> stop at the first invalid digit; later digits read 4'hF with
//                mask bits clear, done follows that capture directly.
//   undefined -> every digit is always converted.
module conv_seq_ctrl #(
  parameter int NDIG = 4
) (
  input  logic          clk,
  input  logic          rst,
  conv_seq_ctrl_if.slave bus,
  output logic [3:0]    conv_e,
  input  logic [3:0]    conv_b,
  input  logic          conv_v
);

  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    word_q;
  logic [W-1:0]    res_q;
  logic [NDIG-1:0] mask_q;

  logic [W-1:0]    word_sh;
  logic [W-1:0]    res_nxt;
  logic [NDIG-1:0] mask_nxt;
  logic            abort;
  logic            last;

  // word_q is consumed by shifting: its low nibble is always the digit that
  // follows the one currently on conv_e, so conv_e can be loaded straight
  // from a register without a variable-index mux.
  assign word_sh = word_q >> 4;
  assign last    = (idx == LAST_IDX);

  // Result accumulator with the current capture merged in.
  always_comb begin
    res_nxt  = res_q;
    mask_nxt = mask_q;
    abort    = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (IW'(i) == idx) begin
        if (conv_v) begin
          res_nxt[4*i +: 4] = conv_b;
          mask_nxt[i]       = 1'b0;
        end else begin
          res_nxt[4*i +: 4] = 4'hF;
          mask_nxt[i]       = 1'b1;
        end
      end
    end
`ifdef CONV_EARLY_ABORT_EN
    if (!conv_v) begin
      abort = 1'b1;
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (IW'(i) > idx) begin
          res_nxt[4*i +: 4] = 4'hF;
          mask_nxt[i]       = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      word_q       <= '0;
      res_q        <= '0;
      mask_q       <= '0;
      conv_e       <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.bcd_out  <= '0;
      bus.err_mask <= '0;
      bus.err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            word_q   <= bus.word_in >> 4;
            conv_e   <= bus.word_in[3:0];
            idx      <= '0;
            res_q    <= '0;
            mask_q   <= '0;
            bus.busy <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          res_q  <= res_nxt;
          mask_q <= mask_nxt;
          if (last || abort) begin
            conv_e       <= '0;
            bus.done     <= 1'b1;
            bus.bcd_out  <= res_nxt;
            bus.err_mask <= mask_nxt;
            bus.err      <= |mask_nxt;
            state        <= DONE;
          end else begin
            idx    <= idx + 1'b1;
            word_q <= word_sh;
            conv_e <= word_q[3:0];
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          conv_e   <= '0;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule
